// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and width helper for the parametrised
//               synchronous FIFO (fifo_sync_param and fifo_mem).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int C_DEF_WIDTH = 8;
    localparam int C_DEF_DEPTH = 16;

    // Address width for a given depth. The level counter is one bit wider
    // so that it can represent the completely full state (level == DEPTH).
    function automatic int fifo_aw(input int depth);
        int aw;
        aw = $clog2(depth);
        if (aw < 1) begin
            aw = 1;
        end
        return aw;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : fifo_mem
// Description : Simple dual-port storage array, WIDTH x DEPTH, synchronous
//               write and asynchronous (combinational) read. Contents are
//               not reset.
// Ports       : clk      - write clock
//               we_i     - write enable
//               waddr_i  - write address
//               wdata_i  - write data
//               raddr_i  - read address
//               rdata_o  - read data (combinational from raddr_i)
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = C_DEF_WIDTH,
    parameter int DEPTH = C_DEF_DEPTH,
    parameter int AW    = fifo_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Parametrised synchronous FIFO with simultaneous push/pop,
//               standard (registered) or first-word-fall-through read mode,
//               occupancy level, almost-full/almost-empty flags and sticky
//               overflow/underflow flags.
// Ports       : clk          - single clock, rising edge
//               reset_n      - asynchronous active-low reset
//               clear        - synchronous flush, overrides push/pop
//               push/data_in - write strobe and data
//               pop          - read strobe
//               data_out     - read data (registered or fall-through)
//               empty/full/almost_empty/almost_full/level - occupancy status
//               overflow/underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH    = C_DEF_WIDTH,
    parameter int DEPTH    = C_DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic                    push,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    pop,
    output logic [WIDTH-1:0]        data_out,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_empty,
    output logic                    almost_full,
    output logic [fifo_aw(DEPTH):0] level,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = fifo_aw(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [LW-1:0]    level_q,     level_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_mem_we;
    logic [WIDTH-1:0] w_mem_rdata;

    // All status flags come straight from the registered level, so they
    // change in the same cycle as the level itself.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(DEPTH));
    assign almost_empty = (int'(level_q) <= AE_LEVEL);
    assign almost_full  = (int'(level_q) >= AF_LEVEL);
    assign level        = level_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses start-of-cycle state only: a pop in the same cycle
    // does not make room for a push into a full FIFO.
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign w_mem_we  = w_push_ok & ~clear;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q | (push & full);
        underflow_d = underflow_q | (pop & empty);

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (w_push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (w_pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (w_mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_mem_rdata)
    );

    generate
        if (FWFT) begin : g_fwft
            // Head of queue is shown directly; forced to zero when empty so
            // stale memory contents never leak out.
            assign data_out = empty ? '0 : w_mem_rdata;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q, dout_d;

            always_comb begin
                dout_d = dout_q;
                if (clear) begin
                    dout_d = '0;
                end else if (w_pop_ok) begin
                    dout_d = w_mem_rdata;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= dout_d;
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule : fifo_sync_param
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_sync_param
// Description : Self-checking bench for fifo_sync_param. Two instances share
//               the same stimulus: one in standard read mode, one in FWFT
//               mode (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       push;
    logic       pop;
    logic [7:0] data_in;

    logic [7:0] s_dout, f_dout;
    logic       s_empty, s_full, s_ae, s_af, s_ovf, s_unf;
    logic       f_empty, f_full, f_ae, f_af, f_ovf, f_unf;
    logic [3:0] s_level, f_level;

    int n_cmp;
    int n_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_param #(
        .WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)
    ) dut_std (
        .clk(clk), .reset_n(reset_n), .clear(clear), .push(push),
        .data_in(data_in), .pop(pop), .data_out(s_dout), .empty(s_empty),
        .full(s_full), .almost_empty(s_ae), .almost_full(s_af),
        .level(s_level), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_param #(
        .WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)
    ) dut_fwft (
        .clk(clk), .reset_n(reset_n), .clear(clear), .push(push),
        .data_in(data_in), .pop(pop), .data_out(f_dout), .empty(f_empty),
        .full(f_full), .almost_empty(f_ae), .almost_full(f_af),
        .level(f_level), .overflow(f_ovf), .underflow(f_unf)
    );

    // flags packed as {empty, full, almost_empty, almost_full, overflow, underflow}
    typedef struct {
        logic       clr;
        logic       psh;
        logic       pp;
        logic [7:0] din;
        logic [3:0] lvl;
        logic [5:0] flg;
        logic [7:0] ds;
        logic [7:0] df;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic c, input logic p, input logic q,
                                input logic [7:0] d, input int lvl,
                                input logic e, input logic f, input logic ae,
                                input logic af, input logic ov, input logic un,
                                input logic [7:0] ds, input logic [7:0] df);
        vec_t v;
        v.clr = c; v.psh = p; v.pp = q; v.din = d;
        v.lvl = 4'(lvl);
        v.flg = {e, f, ae, af, ov, un};
        v.ds  = ds; v.df = df;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic c, input logic p, input logic q,
                         input logic [7:0] d);
        clear = c; push = p; pop = q; data_in = d;
        @(posedge clk);
        #1;
        clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk("rst_level", idx, 32'(s_level), 32'd0);
        chk("rst_flags", idx, 32'({s_empty, s_full, s_ae, s_af, s_ovf, s_unf}), 32'b101000);
        chk("rst_dout_std", idx, 32'(s_dout), 32'h00);
        chk("rst_dout_fwft", idx, 32'(f_dout), 32'h00);
        chk("rst_flags_fwft", idx, 32'({f_empty, f_full, f_ae, f_af, f_ovf, f_unf}), 32'b101000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq [14];
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;

        // ------------------------------------------------ vector table
        // fill 0x11..0x18
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 8'(8'h11 + i), i + 1, 0, (i == 7), (i == 0), (i + 1 >= 6), 0, 0, 8'h00, 8'h11));
        // ninth push rejected
        tbl.push_back(mk(0, 1, 0, 8'h99, 8, 0, 1, 0, 1, 1, 0, 8'h00, 8'h11));
        // drain: std word appears after its pop, FWFT shows the next head
        for (int j = 1; j <= 8; j++)
            tbl.push_back(mk(0, 0, 1, 8'h00, 8 - j, (j == 8), 0, (8 - j <= 1), (8 - j >= 6), 1, 0,
                             8'(8'h10 + j), (j == 8) ? 8'h00 : 8'(8'h11 + j)));
        // pop while empty
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 1, 1, 8'h18, 8'h00));
        // clear flushes everything
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        // wrap: push 5, pop 5, then 0xA0..0xA7 across the pointer wrap
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 1, 0, 8'(8'h31 + i), i + 1, 0, 0, (i == 0), 0, 0, 0, 8'h00, 8'h31));
        for (int j = 1; j <= 5; j++)
            tbl.push_back(mk(0, 0, 1, 8'h00, 5 - j, (j == 5), 0, (5 - j <= 1), 0, 0, 0,
                             8'(8'h30 + j), (j == 5) ? 8'h00 : 8'(8'h31 + j)));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 0, 8'(8'hA0 + i), i + 1, 0, (i == 7), (i == 0), (i + 1 >= 6), 0, 0, 8'h35, 8'hA0));
        for (int j = 1; j <= 8; j++)
            tbl.push_back(mk(0, 0, 1, 8'h00, 8 - j, (j == 8), 0, (8 - j <= 1), (8 - j >= 6), 0, 0,
                             8'(8'h9F + j), (j == 8) ? 8'h00 : 8'(8'hA0 + j)));
        // level 4, then 10 cycles of push+pop
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 0, 8'(8'hC0 + i), i + 1, 0, 0, (i == 0), 0, 0, 0, 8'hA7, 8'hC0));
        for (int k = 0; k < 14; k++) begin
            logic [7:0] t;
            t = (k < 4) ? 8'(8'hC0 + k) : 8'(8'hD0 + k - 4);
            seq[k] = t;
        end
        for (int k = 0; k < 10; k++)
            tbl.push_back(mk(0, 1, 1, 8'(8'hD0 + k), 4, 0, 0, 0, 0, 0, 0, seq[k], seq[k + 1]));
        // refill to full (D6..D9 remain, add E0..E3)
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 0, 8'(8'hE0 + i), 5 + i, 0, (i == 3), 0, (5 + i >= 6), 0, 0, 8'hD5, 8'hD6));
        // push+pop while full: push rejected, pop accepted
        tbl.push_back(mk(0, 1, 1, 8'hEE, 7, 0, 0, 0, 1, 1, 0, 8'hD6, 8'hD7));
        // push+pop while empty: push accepted, pop rejected
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 1, 8'h5A, 1, 0, 0, 1, 0, 0, 1, 8'h00, 8'h5A));
        tbl.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 0, 0, 1, 8'h00, 8'h5A));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 1, 8'h5A, 8'h00));
        // three words then clear with push asserted: nothing written
        tbl.push_back(mk(0, 1, 0, 8'h01, 1, 0, 0, 1, 0, 0, 1, 8'h5A, 8'h01));
        tbl.push_back(mk(0, 1, 0, 8'h02, 2, 0, 0, 0, 0, 0, 1, 8'h5A, 8'h01));
        tbl.push_back(mk(0, 1, 0, 8'h03, 3, 0, 0, 0, 0, 0, 1, 8'h5A, 8'h01));
        tbl.push_back(mk(1, 1, 0, 8'h77, 0, 1, 0, 1, 0, 0, 0, 8'h00, 8'h00));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 1, 0, 1, 0, 0, 1, 8'h00, 8'h00));
        tbl.push_back(mk(0, 1, 0, 8'h42, 1, 0, 0, 1, 0, 0, 1, 8'h00, 8'h42));

        // ------------------------------------------------ reset release
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_outputs(-1);

        // ------------------------------------------------ table run
        foreach (tbl[i]) begin
            apply(tbl[i].clr, tbl[i].psh, tbl[i].pp, tbl[i].din);
            chk("level", i, 32'(s_level), 32'(tbl[i].lvl));
            chk("flags", i, 32'({s_empty, s_full, s_ae, s_af, s_ovf, s_unf}), 32'(tbl[i].flg));
            chk("dout_std", i, 32'(s_dout), 32'(tbl[i].ds));
            chk("dout_fwft", i, 32'(f_dout), 32'(tbl[i].df));
        end

        // ------------------------------------------------ async reset mid-stream
        apply(0, 1, 0, 8'h43);
        apply(0, 0, 1, 8'h00);
        chk("pre_rst_dout_std", 0, 32'(s_dout), 32'h42);
        chk("pre_rst_level", 0, 32'(s_level), 32'd1);
        #3 reset_n = 1'b0;      // well before the next rising edge
        #1;
        chk_reset_outputs(0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        chk_reset_outputs(1);
        @(posedge clk);
        #1;
        apply(0, 1, 0, 8'h66);
        chk("post_rst_level", 0, 32'(s_level), 32'd1);
        chk("post_rst_dout_fwft", 0, 32'(f_dout), 32'h66);
        apply(0, 0, 1, 8'h00);
        chk("post_rst_dout_std", 0, 32'(s_dout), 32'h66);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_sync_param
`default_nettype wire
